// File: rtl/reg_file32_if.sv
// Bus bundle for the 32-entry register file: one write port, two read ports,
// plus the decoded write-enable vector for observation.
interface reg_file32_if #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 5
);
   logic                   wr_en;
   logic [ADDR_W-1:0]      wr_reg_no;
   logic [WIDTH-1:0]       wr_data;
   logic [ADDR_W-1:0]      rd_reg_no1;
   logic [ADDR_W-1:0]      rd_reg_no2;
   logic [WIDTH-1:0]       regData1;
   logic [WIDTH-1:0]       regData2;
   logic [2**ADDR_W-1:0]   wr_onehot;

   modport master (
      output wr_en, wr_reg_no, wr_data, rd_reg_no1, rd_reg_no2,
      input  regData1, regData2, wr_onehot
   );

   modport slave (
      input  wr_en, wr_reg_no, wr_data, rd_reg_no1, rd_reg_no2,
      output regData1, regData2, wr_onehot
   );
endinterface

// File: rtl/reg_file32.sv
// 2**ADDR_W x WIDTH register file with one-hot write decode, optional hardwired
// zero register and optional same-cycle write-to-read forwarding.
module reg_file32 #(
   parameter int WIDTH    = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic         clk,
   input  logic         reset,
   reg_file32_if.slave  rf
);
   localparam int NREG = 2**ADDR_W;

   logic [WIDTH-1:0] regs_q [NREG];
   logic [WIDTH-1:0] regs_d [NREG];
   logic [NREG-1:0]  wr_onehot;
   logic             zero_hit;
   logic             wr_commit;
   logic [WIDTH-1:0] rd_data1;
   logic [WIDTH-1:0] rd_data2;

   // Decode is unmasked by the zero register; only reset and wr_en gate it.
   always_comb begin
      wr_onehot = '0;
      if (reset && rf.wr_en) begin
         wr_onehot[rf.wr_reg_no] = 1'b1;
      end
   end

   assign zero_hit  = (ZERO_REG != 0) && (rf.wr_reg_no == '0);
   assign wr_commit = reset && rf.wr_en && !zero_hit;

   always_comb begin
      regs_d = regs_q;
      if (wr_commit) begin
         regs_d[rf.wr_reg_no] = rf.wr_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // Forwarding keys off wr_commit so a dropped zero-register write never forwards.
   always_comb begin
      rd_data1 = regs_q[rf.rd_reg_no1];
      if ((BYPASS != 0) && wr_commit && (rf.wr_reg_no == rf.rd_reg_no1)) begin
         rd_data1 = rf.wr_data;
      end
      if (!reset || ((ZERO_REG != 0) && (rf.rd_reg_no1 == '0))) begin
         rd_data1 = '0;
      end
   end

   always_comb begin
      rd_data2 = regs_q[rf.rd_reg_no2];
      if ((BYPASS != 0) && wr_commit && (rf.wr_reg_no == rf.rd_reg_no2)) begin
         rd_data2 = rf.wr_data;
      end
      if (!reset || ((ZERO_REG != 0) && (rf.rd_reg_no2 == '0))) begin
         rd_data2 = '0;
      end
   end

   assign rf.regData1  = rd_data1;
   assign rf.regData2  = rd_data2;
   assign rf.wr_onehot = wr_onehot;
endmodule

// File: tb/tb_reg_file32.sv
// Randomized self-checking bench for reg_file32 (ZERO_REG=1, BYPASS=1) against
// an array-based reference model.
module tb_reg_file32;
   localparam int WIDTH  = 32;
   localparam int ADDR_W = 5;
   localparam int NREG   = 32;

   logic clk = 1'b0;
   logic reset;

   reg_file32_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) rf ();

   reg_file32 #(
      .WIDTH(WIDTH), .ADDR_W(ADDR_W), .ZERO_REG(1), .BYPASS(1)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .rf    (rf)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] mem  [NREG];
   logic [31:0] snap [NREG];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_rd(input int r);
      if (!reset || r == 0) return 32'h0;
      if (rf.wr_en && int'(rf.wr_reg_no) == r) return rf.wr_data;
      return mem[r];
   endfunction

   function automatic logic [31:0] exp_onehot();
      if (reset && rf.wr_en) return 32'd1 << rf.wr_reg_no;
      return 32'h0;
   endfunction

   task automatic check_all(input string tag);
      chk({tag, ".rd1"},    rf.regData1,  exp_rd(int'(rf.rd_reg_no1)));
      chk({tag, ".rd2"},    rf.regData2,  exp_rd(int'(rf.rd_reg_no2)));
      chk({tag, ".onehot"}, rf.wr_onehot, exp_onehot());
   endtask

   task automatic drive(input logic we, input int wn, input logic [31:0] wd,
                        input int r1, input int r2);
      rf.wr_en      = we;
      rf.wr_reg_no  = 5'(wn);
      rf.wr_data    = wd;
      rf.rd_reg_no1 = 5'(r1);
      rf.rd_reg_no2 = 5'(r2);
      #1;
   endtask

   // Model the clock edge, then return to the falling edge for the next drive.
   task automatic tick();
      @(posedge clk);
      if (reset && rf.wr_en && rf.wr_reg_no != 0) mem[rf.wr_reg_no] = rf.wr_data;
      @(negedge clk);
   endtask

   task automatic reset_pulse(input string tag);
      reset = 1'b0;
      #1;
      for (int i = 0; i < NREG; i++) mem[i] = 32'h0;
      chk({tag, ".rd1_in_rst"}, rf.regData1, 32'h0);
      chk({tag, ".rd2_in_rst"}, rf.regData2, 32'h0);
      chk({tag, ".oh_in_rst"},  rf.wr_onehot, 32'h0);
      #2;
      reset = 1'b1;
      #0;
   endtask

   initial begin
      reset = 1'b0;
      for (int i = 0; i < NREG; i++) mem[i] = 32'h0;
      drive(1'b0, 0, 32'h0, 0, 0);
      @(negedge clk);

      // Reset held with a pending write.
      drive(1'b1, 5, 32'hDEAD_BEEF, 5, 5);
      for (int k = 0; k < 3; k++) begin
         chk("rst_hold.rd1", rf.regData1, 32'h0);
         chk("rst_hold.oh",  rf.wr_onehot, 32'h0);
         tick();
      end
      reset = 1'b1;
      drive(1'b0, 5, 32'hDEAD_BEEF, 5, 5);
      chk("rst_rel.rd1", rf.regData1, 32'h0);
      tick();
      chk("rst_rel_edge.rd1", rf.regData1, 32'h0);

      // Load 1..31, then sweep both read ports in opposite directions.
      for (int i = 1; i < NREG; i++) begin
         drive(1'b1, i, 32'h1000_0000 + 32'(i), i, 0);
         check_all("load");
         tick();
      end
      for (int i = 0; i < NREG; i++) begin
         drive(1'b0, 0, 32'h0, i, NREG - 1 - i);
         chk("sweep.rd1", rf.regData1, (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i));
         chk("sweep.rd2", rf.regData2,
             (i == NREG - 1) ? 32'h0 : 32'h1000_0000 + 32'(NREG - 1 - i));
      end

      // Zero-register write is dropped but still decoded.
      drive(1'b1, 0, 32'hFFFF_FFFF, 0, 0);
      chk("zero.pre_rd1", rf.regData1, 32'h0);
      chk("zero.onehot",  rf.wr_onehot, 32'h0000_0001);
      tick();
      drive(1'b0, 0, 32'h0, 0, 0);
      chk("zero.post_rd1", rf.regData1, 32'h0);

      // Same-cycle forwarding on port 1 only.
      drive(1'b1, 7, 32'hAAAA_AAAA, 1, 2);
      tick();
      drive(1'b1, 7, 32'h5555_5555, 7, 8);
      chk("byp.pre_rd1", rf.regData1, 32'h5555_5555);
      chk("byp.pre_rd2", rf.regData2, 32'h1000_0008);
      tick();
      drive(1'b0, 0, 32'h0, 7, 8);
      chk("byp.post_rd1", rf.regData1, 32'h5555_5555);
      chk("byp.post_rd2", rf.regData2, 32'h1000_0008);

      // Asynchronous reset pulse between edges, then a normal write.
      drive(1'b0, 0, 32'h0, 3, 31);
      reset_pulse("async");
      check_all("async_after");
      tick();
      drive(1'b1, 9, 32'h1234_5678, 9, 3);
      tick();
      drive(1'b0, 0, 32'h0, 9, 3);
      chk("async_write.rd1", rf.regData1, 32'h1234_5678);
      chk("async_write.rd2", rf.regData2, 32'h0);

      // Decode sweep, then 32 idle edges with garbage on the write bus.
      for (int i = 0; i < NREG; i++) begin
         drive(1'b1, i, $urandom, i, int'($urandom_range(0, NREG - 1)));
         chk("decode.onehot", rf.wr_onehot, 32'd1 << i);
         check_all("decode");
         tick();
      end
      for (int i = 0; i < NREG; i++) snap[i] = mem[i];
      for (int k = 0; k < NREG; k++) begin
         drive(1'b0, int'($urandom_range(0, NREG - 1)), $urandom,
               int'($urandom_range(0, NREG - 1)), int'($urandom_range(0, NREG - 1)));
         chk("idle.onehot", rf.wr_onehot, 32'h0);
         tick();
      end
      for (int i = 0; i < NREG; i++) begin
         drive(1'b0, 0, 32'h0, i, i);
         chk("idle.hold", rf.regData1, snap[i]);
      end

      // Random traffic with read/write collisions and occasional reset pulses.
      for (int k = 0; k < 600; k++) begin
         int wn;
         int r1;
         int r2;
         wn = int'($urandom_range(0, NREG - 1));
         r1 = ($urandom_range(0, 3) == 0) ? wn : int'($urandom_range(0, NREG - 1));
         r2 = ($urandom_range(0, 3) == 0) ? wn : int'($urandom_range(0, NREG - 1));
         drive(1'($urandom_range(0, 1)), wn, $urandom, r1, r2);
         if ($urandom_range(0, 39) == 0) reset_pulse("rand_rst");
         check_all("rand");
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/reg_file32.md
Name: reg_file32

Overview:
- 32-entry x 32-bit register file: the storage end of the read-select and write-select path.
- The write side decodes the write register number into a one-hot load enable.
- The two read sides select a register onto regData1/regData2.
- Sits between the datapath write-back stage and the operand fetch of the lab CPU datapath.

Parameters:
- WIDTH, 32, data width of each register.
- ADDR_W, 5, register-number width; number of registers = 2**ADDR_W.
- ZERO_REG, 1, 1 = register 0 is hardwired to zero and writes to it are ignored; 0 = register 0 is an ordinary register.
- BYPASS, 1, 1 = write-to-read forwarding in the same cycle; 0 = a read returns the pre-edge contents.

Ports:
- clk  input  1  rising-edge clock for all register updates.
- reset  input  1  asynchronous, active-low reset; clears every register.
- wr_en  input  1  write enable, sampled on rising clk.
- wr_reg_no  input  ADDR_W  destination register number.
- wr_data  input  WIDTH  write data.
- rd_reg_no1  input  ADDR_W  read port 1 register number.
- rd_reg_no2  input  ADDR_W  read port 2 register number.
- regData1  output  WIDTH  read port 1 data, combinational.
- regData2  output  WIDTH  read port 2 data, combinational.
- wr_onehot  output  2**ADDR_W  decoded load-enable vector, for debug and observation.

Behaviour:
- Clocking and reset:
  - One clock domain.
  - reset low forces all 2**ADDR_W registers to 0 immediately, without waiting for a clock edge.
  - While reset is low, writes are blocked and regData1/regData2 read 0.
  - Reset deassertion is synchronised externally; the block needs no internal synchroniser.
- Write decode:
  - wr_onehot = (1 << wr_reg_no) when wr_en=1, else all zeros.
  - Exactly one bit is set when enabled.
  - wr_onehot is combinational and is forced to 0 while reset is low.
- Write:
  - On rising clk with reset high and wr_en=1, register[wr_reg_no] <= wr_data.
  - All other registers hold their value.
  - Write latency is one edge: data is visible in storage from the cycle after the edge.
- ZERO_REG=1:
  - A write with wr_reg_no=0 is dropped. Register 0 stays 0 and wr_onehot[0] is still asserted (decode is unmasked).
  - Reads of register 0 return 0 on both ports, regardless of BYPASS.
- Read:
  - regDataN = register[rd_reg_noN], combinational from rd_reg_noN and storage.
  - Both ports are independent; the same register on both ports is allowed.
- BYPASS=1:
  - If wr_en=1 and wr_reg_no == rd_reg_noN (and the target is not the zero register when ZERO_REG=1), regDataN = wr_data in the same cycle, before the edge.
  - Applies to each port independently.
- BYPASS=0: reads return the stored value and the new value appears after the edge.
- Simultaneous events:
  - Write and read of the same register follow the BYPASS rule.
  - Write to one register while reading others gives no interaction.
  - Reset asserted mid-cycle with wr_en=1: reset wins and no write occurs at that edge.
- No X propagation: every register has a defined reset value, and an out-of-range index is impossible by width.

Test Plan:
- Reset: hold reset=0, drive wr_en=1 wr_reg_no=5 wr_data=32'hDEAD_BEEF over 3 edges -> regData1 (rd 5) = 0 and wr_onehot = 0 throughout; release reset -> still 0 until the next write edge.
- Write/read all: write register i = 32'h1000_0000+i for i=1..31, then sweep rd_reg_no1=0..31 and rd_reg_no2=31..0 -> regData = 32'h1000_0000+i for i>=1; register 0 reads 0 (ZERO_REG=1).
- Zero register: write 32'hFFFF_FFFF to register 0 -> regData1 (rd 0) = 0 before and after the edge; wr_onehot = 32'h0000_0001 during the write cycle.
- Bypass: with register 7 = 32'hAAAA_AAAA, drive wr_en=1 wr_reg_no=7 wr_data=32'h5555_5555 rd_reg_no1=7 rd_reg_no2=8 -> pre-edge regData1 = 32'h5555_5555 (BYPASS=1) or 32'hAAAA_AAAA (BYPASS=0), regData2 unchanged; post-edge regData1 = 32'h5555_5555 in both builds.
- Async reset mid-operation: after loading registers 1..31, pulse reset low for 3 ns between edges -> all reads immediately return 0; the next enabled write then lands normally.
- Decode check: wr_en=1, sweep wr_reg_no 0..31 -> wr_onehot = 1<<wr_reg_no; wr_en=0 -> wr_onehot = 0 and no register changes over 32 edges.
